// File: rtl/md_unit_if.sv
// Handshake/bus bundle between the E-stage control and the multiply/divide unit.
interface md_unit_if;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hilo_we;
  logic        hilo_sel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, md_op, A, B, hilo_we, hilo_sel,
    input  busy, HI, LO
  );

  modport slave (
    input  start, md_op, A, B, hilo_we, hilo_sel,
    output busy, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers for the E stage.
// Operands are latched at start; the result lands in HI/LO on the last busy cycle.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);

  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} md_op_e;
  typedef enum logic {IDLE, RUN} state_e;

  state_e      state;
  md_op_e      op_q;
  logic [3:0]  cnt;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q;

  logic        op_signed, op_is_div, div_zero;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    op_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    div_zero  = (b_q == '0);

    // One 64-bit multiplier serves both signednesses; the low 64 bits of the
    // sign-extended product equal the true signed product.
    a_ext = op_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext = op_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod  = a_ext * b_ext;

    // Signed divide on magnitudes: truncates toward zero, remainder follows
    // the dividend, and 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
    a_neg = op_signed && a_q[31];
    b_neg = op_signed && b_q[31];
    a_mag = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag = b_neg ? (~b_q + 32'd1) : b_q;
    q_mag = '0;
    r_mag = '0;
    if (!div_zero) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem  = a_neg ? (~r_mag + 32'd1) : r_mag;

    res_hi = op_is_div ? rem  : prod[63:32];
    res_lo = op_is_div ? quot : prod[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= OP_MULT;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            op_q   <= md_op_e'(bus.md_op);
            cnt    <= bus.md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            busy_q <= 1'b1;
            state  <= RUN;
          end else if (bus.hilo_we) begin
            if (bus.hilo_sel) hi_q <= bus.A;
            else              lo_q <= bus.A;
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            busy_q <= 1'b0;
            state  <= IDLE;
            if (!(op_is_div && div_zero)) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the pipelined MIPS CPU.
- Holds the HI/LO architectural registers and executes mult, multu, div, divu, mthi and mtlo.
- Drives the busy indication consumed by the stall unit and by the register-file write gate.
- mfhi/mflo results come from the hi/lo outputs and are forwarded down the pipeline to W-stage writeback.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu; legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle strobe that launches the operation selected by md_op.
- md_op  input  2  0=mult, 1=multu, 2=div, 3=divu; sampled only when start=1.
- A  input  32  rs operand; dividend for div/divu.
- B  input  32  rt operand; divisor for div/divu.
- hilo_we  input  1  mthi/mtlo write strobe.
- hilo_sel  input  1  0=write LO, 1=write HI; sampled only when hilo_we=1.
- busy  output  1  high while an operation is in flight.
- HI  output  32  HI register value.
- LO  output  32  LO register value.

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, busy=0, cycle counter=0, operand/op latches=0. Reset wins over every other input in the same cycle.
- Reset mid-operation: the operation aborts; HI/LO go to 0, not to the pending result.
- States:
  - IDLE (busy=0). On an edge with start=1: latch A, B and md_op; load counter with MULT_CYCLES (md_op 0/1) or DIV_CYCLES (md_op 2/3); go to RUN.
  - RUN (busy=1). Each edge decrements the counter. On the edge where the counter goes 1->0: HI/LO take the result, busy drops, state returns to IDLE.
- Timing:
  - busy is a registered output.
  - busy is high for exactly L cycles, where L = MULT_CYCLES or DIV_CYCLES.
  - If start is sampled at edge N, the result is visible on HI/LO starting after edge N+L.
  - HI/LO keep their old values during RUN.
- Arithmetic:
  - mult: signed 32x32->64; HI = upper 32 bits, LO = lower 32 bits.
  - multu: the same, unsigned.
  - div: signed; LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Results are computed from the latched operands, so A and B may change after the start cycle without effect.
  - Divide by zero (B=0 latched): the unit still stays busy for DIV_CYCLES; HI/LO are left unchanged.
  - Signed overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: with hilo_we=1 and busy=0, the selected register takes A at the edge; the other register is unchanged; the write takes 1 cycle.
- start while busy=1: ignored; the in-flight operation continues unaffected.
- hilo_we while busy=1: ignored.
- start and hilo_we in the same IDLE cycle: start wins and hilo_we is dropped. The stall unit must never issue both; this is illegal upstream.
- An operation may be launched on the first cycle after busy drops; back-to-back operations need no idle gap.
- No flush input. Squashing an instruction before E is the hazard unit's job; once start is sampled, the operation commits.

Test Plan:
- Signed multiply: reset, then start with md_op=0, A=0xFFFFFFFE (-2), B=3 -> busy=1 for 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned multiply with operand change: md_op=1, A=B=0xFFFFFFFF, then change A and B on the next cycle -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001; operand change has no effect.
- Signed divide: md_op=2, A=0xFFFFFFF9 (-7), B=2 -> busy=1 for 10 cycles; afterwards LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned divide then divide by zero: md_op=3, A=100, B=7 -> LO=14, HI=2. Then div with B=0 -> busy for 10 cycles; HI=2, LO=14 unchanged.
- Writes ignored while busy: start mult, then pulse start and hilo_we while busy -> both ignored; result matches the first operation only. After busy drops: hilo_we=1, hilo_sel=1, A=0x12345678 -> next cycle HI=0x12345678, LO unchanged.
- Reset and back-to-back: reset asserted on the 3rd busy cycle of a div -> next cycle busy=0, HI=LO=0. Then start mult, and start a second mult on the first cycle busy=0 -> accepted; both results correct.
